sincronizador_gray_binario: RTL
===============================

# sincronizador_gray_binario

Receives a Gray-coded value produced in another timing domain, for example a Gray pointer or counter. It passes the value through a multi-flop synchronizer, converts it to binary and reports each change with a one-cycle strobe and a direction flag. It also flags any step that is not a legal single-bit Gray transition. It is the downstream consumer of the binary-to-Gray encoder and carries its output safely into the local clock domain.

## Interface
- ANCHO, 4, code width in bits (≥2)
- ETAPAS, 2, synchronizer flop stages (≥2)
- clk  input  1  local clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- Gray  input  ANCHO  Gray code, asynchronous to clk
- Limpiar  input  1  synchronous clear of sticky Error
- Binario  output  ANCHO  registered binary equivalent of the synchronized Gray value
- Valido  output  1  one-cycle strobe: Binario just took a new value
- Sentido  output  1  valid with Valido: 1 means new = old+1 mod 2^ANCHO, else 0
- Error  output  1  sticky: a change of more than one bit was observed
- ConteoErrores  output  8  present only with CONTADOR_ERRORES_EN

## Operation
- Sync chain: ETAPAS registers. Gray feeds stage 0 only. No logic is allowed between stages. g_s is the last stage.
- g_p register holds the last accepted Gray value.
- Conversion: b[ANCHO-1]=g[ANCHO-1]; b[i]=b[i+1]^g[i].
- FSM states and transitions:
  - ARRANQUE: after reset, count ETAPAS edges to flush the chain, then go to CARGA.
  - CARGA, one cycle: g_p<=g_s, Binario<=g2b(g_s), Valido=0, no error check. Then go to OPERACION.
  - OPERACION: on each edge, if g_s≠g_p:
    - g_p<=g_s, Binario<=g2b(g_s), Valido<=1.
    - Sentido<=(g2b(g_s)==Binario+1 mod 2^ANCHO).
    - If popcount(g_s^g_p)>1, Error<=1. Binario still updates.
  - OPERACION: if g_s==g_p, Valido<=0 and Sentido<=0.
- Limpiar in any state clears Error next edge. If a new multi-bit error occurs in the same cycle as Limpiar, Error stays 1.
- Wrap-around: Gray 100…0 → 000…0 is legal. Binario goes from 2^ANCHO−1 to 0 with Sentido=1.
- Decrement, e.g. binary 3→2, gives Valido=1, Sentido=0, Error=0.
- Reset values: sync chain 0, g_p 0, Binario 0, Valido 0, Sentido 0, Error 0, ConteoErrores 0, FSM ARRANQUE.

## Timing
- rst asserted at any time, including mid-transition, forces the reset values immediately, without waiting for clk. On deassertion, sequencing restarts from ARRANQUE.
- First Binario load occurs on edge ETAPAS+1 after rst deassertion, with no Valido.
- Latency in OPERACION: a Gray change captured by stage 0 at edge k gives Binario/Valido/Sentido at edge k+ETAPAS.
- Valido is never high for two consecutive cycles unless g_s changes on consecutive cycles.
- Input steadiness: Gray must hold each value for ≥ETAPAS+1 clk cycles. Faster input is undefined apart from possible Error.

## Configuration
- CONTADOR_ERRORES_EN defined:
  - ConteoErrores increments on every detected multi-bit change and saturates at 255.
  - It is cleared by rst and by Limpiar.
  - If Limpiar and an error occur in the same cycle, the result is 1.
- Not defined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package holds:
  - the FSM state encoding (ARRANQUE, CARGA, OPERACION)
  - the default ANCHO/ETAPAS constants
  - the g2b conversion function, shared with the encoder bench
- Sub-module sincronizador_multietapa (ANCHO bits × ETAPAS flops, async reset to 0) is instantiated once.

## Test plan
All scenarios use ANCHO=4 and ETAPAS=2.
- Reset release with Gray=0110:
  - Binario=0100 on edge 3.
  - Valido=0, Error=0 throughout.
- OPERACION, Gray 0000→0001:
  - Three edges later, Binario=0001, Valido=1 for one cycle, Sentido=1.
- Gray 0010→0011 (binary 3→2):
  - Binario=0010, Valido=1, Sentido=0, Error=0.
- Wrap, Gray 1000→0000:
  - Binario 1111→0000, Sentido=1, Error=0.
- Gray 0000→0011:
  - Binario=0010, Valido=1, Error=1 and holding.
  - Limpiar pulse gives Error=0 next edge.
  - With the macro, ConteoErrores=1 then 0.
- rst asserted mid-OPERACION with Binario=1010:
  - All outputs 0 immediately.
  - After release, Binario reloads on edge 3 without Valido.

Source files
------------

// File: rtl/sincronizador_gray_binario_pkg.sv
// Shared definitions for the Gray-to-binary synchronizer: FSM encoding,
// default geometry and the Gray-to-binary conversion.
package sincronizador_gray_binario_pkg;

  localparam int ANCHO_DEF  = 4;
  localparam int ETAPAS_DEF = 2;

  typedef enum logic [1:0] {
    ARRANQUE  = 2'd0,
    CARGA     = 2'd1,
    OPERACION = 2'd2
  } estado_t;

  // Zero-extended input keeps this width-agnostic: b[i] is the XOR of g[i] and every bit above it.
  function automatic logic [31:0] g2b(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sincronizador_gray_binario_if.sv
// Bus bundle between the Gray source side and the synchronizer.
// ConteoErrores exists only when CONTADOR_ERRORES_EN is defined.
interface sincronizador_gray_binario_if
  import sincronizador_gray_binario_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) ();

  logic [ANCHO-1:0] Gray;
  logic             Limpiar;
  logic [ANCHO-1:0] Binario;
  logic             Valido;
  logic             Sentido;
  logic             Error;
`ifdef CONTADOR_ERRORES_EN
  logic [7:0]       ConteoErrores;
`endif

`ifdef CONTADOR_ERRORES_EN
  modport master (output Gray, Limpiar, input Binario, Valido, Sentido, Error, ConteoErrores);
  modport slave  (input Gray, Limpiar, output Binario, Valido, Sentido, Error, ConteoErrores);
`else
  modport master (output Gray, Limpiar, input Binario, Valido, Sentido, Error);
  modport slave  (input Gray, Limpiar, output Binario, Valido, Sentido, Error);
`endif

endinterface

// File: rtl/sincronizador_gray_binario_multietapa.sv
// Plain flop chain bringing an asynchronous Gray bus into the clk domain.
// No logic between stages so each bit only sees metastability settling time.
module sincronizador_multietapa #(
  parameter int ANCHO  = 4,
  parameter int ETAPAS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] d_i,
  output logic [ANCHO-1:0] q_o
);

  logic [ANCHO-1:0] etapa_q [ETAPAS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ETAPAS; i++) begin
        etapa_q[i] <= '0;
      end
    end else begin
      etapa_q[0] <= d_i;
      for (int i = 1; i < ETAPAS; i++) begin
        etapa_q[i] <= etapa_q[i-1];
      end
    end
  end

  assign q_o = etapa_q[ETAPAS-1];

endmodule

// File: rtl/sincronizador_gray_binario.sv
// Synchronizes a Gray code, converts it to binary, strobes each change with
// direction and flags illegal multi-bit steps. Optional: CONTADOR_ERRORES_EN.
module sincronizador_gray_binario
  import sincronizador_gray_binario_pkg::*;
#(
  parameter int ANCHO  = ANCHO_DEF,
  parameter int ETAPAS = ETAPAS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  sincronizador_gray_binario_if.slave   bus
);

  localparam int CW = $clog2(ETAPAS + 1);

  logic [ANCHO-1:0] g_s;
  logic [ANCHO-1:0] g_bin;
  logic [ANCHO-1:0] diff;
  logic             nuevo_err;

  estado_t          estado_q, estado_d;
  logic [CW-1:0]    cuenta_q, cuenta_d;
  logic [ANCHO-1:0] g_p_q, g_p_d;
  logic [ANCHO-1:0] binario_q, binario_d;
  logic             valido_q, valido_d;
  logic             sentido_q, sentido_d;
  logic             error_q, error_d;
`ifdef CONTADOR_ERRORES_EN
  logic [7:0]       conteo_q, conteo_d;
`endif

  sincronizador_multietapa #(
    .ANCHO  (ANCHO),
    .ETAPAS (ETAPAS)
  ) u_sinc (
    .clk (clk),
    .rst (rst),
    .d_i (bus.Gray),
    .q_o (g_s)
  );

  assign g_bin = ANCHO'(g2b(32'(g_s)));
  assign diff  = g_s ^ g_p_q;

  always_comb begin
    estado_d  = estado_q;
    cuenta_d  = cuenta_q;
    g_p_d     = g_p_q;
    binario_d = binario_q;
    valido_d  = 1'b0;
    sentido_d = 1'b0;
    nuevo_err = 1'b0;

    case (estado_q)
      // Let whatever was in the chain at reset release drain out before trusting g_s.
      ARRANQUE: begin
        if (cuenta_q == CW'(ETAPAS - 1)) begin
          cuenta_d = '0;
          estado_d = CARGA;
        end else begin
          cuenta_d = cuenta_q + CW'(1);
        end
      end
      CARGA: begin
        g_p_d     = g_s;
        binario_d = g_bin;
        estado_d  = OPERACION;
      end
      OPERACION: begin
        if (g_s != g_p_q) begin
          g_p_d     = g_s;
          binario_d = g_bin;
          valido_d  = 1'b1;
          sentido_d = (g_bin == binario_q + ANCHO'(1));
          nuevo_err = ($countones(diff) > 1);
        end
      end
      default: estado_d = ARRANQUE;
    endcase

    // A fresh error wins over a simultaneous clear.
    error_d = (error_q & ~bus.Limpiar) | nuevo_err;

`ifdef CONTADOR_ERRORES_EN
    conteo_d = conteo_q;
    if (bus.Limpiar) begin
      conteo_d = nuevo_err ? 8'd1 : 8'd0;
    end else if (nuevo_err && conteo_q != 8'hFF) begin
      conteo_d = conteo_q + 8'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= ARRANQUE;
      cuenta_q  <= '0;
      g_p_q     <= '0;
      binario_q <= '0;
      valido_q  <= 1'b0;
      sentido_q <= 1'b0;
      error_q   <= 1'b0;
`ifdef CONTADOR_ERRORES_EN
      conteo_q  <= '0;
`endif
    end else begin
      estado_q  <= estado_d;
      cuenta_q  <= cuenta_d;
      g_p_q     <= g_p_d;
      binario_q <= binario_d;
      valido_q  <= valido_d;
      sentido_q <= sentido_d;
      error_q   <= error_d;
`ifdef CONTADOR_ERRORES_EN
      conteo_q  <= conteo_d;
`endif
    end
  end

  assign bus.Binario = binario_q;
  assign bus.Valido  = valido_q;
  assign bus.Sentido = sentido_q;
  assign bus.Error   = error_q;
`ifdef CONTADOR_ERRORES_EN
  assign bus.ConteoErrores = conteo_q;
`endif

endmodule
